// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared encodings and byte-enable helper for the memory port arbiter
package mem_arb_pkg;

    localparam logic [1:0] LEN_BYTE = 2'b00;
    localparam logic [1:0] LEN_HALF = 2'b01;
    localparam logic [1:0] LEN_WORD = 2'b10;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_BUSY_I = 2'd1;
    localparam logic [1:0] S_BUSY_D = 2'd2;
    localparam logic [1:0] S_DRAIN  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE   = S_IDLE,
        ST_BUSY_I = S_BUSY_I,
        ST_BUSY_D = S_BUSY_D,
        ST_DRAIN  = S_DRAIN
    } arb_state_e;

    function automatic logic [3:0] be_gen(input logic [1:0] len, input logic [1:0] addr_lo);
        case (len)
            LEN_BYTE: be_gen = 4'b0001 << addr_lo;
            LEN_HALF: be_gen = 4'b0011 << addr_lo;
            default:  be_gen = 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/mem_lane_gen.sv
// rtl/mem_lane_gen.sv - byte enables, lane-replicated store data and alignment check
module mem_lane_gen
    import mem_arb_pkg::*;
(
    input  logic [1:0]  i_len,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_wdata,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata,
    output logic        o_misalign
);

    always_comb begin
        o_be       = be_gen(i_len, i_addr_lo);
        o_misalign = 1'b0;
        o_wdata    = i_wdata;
        case (i_len)
            LEN_BYTE: o_wdata = {4{i_wdata[7:0]}};
            LEN_HALF: begin
                o_wdata    = {2{i_wdata[15:0]}};
                o_misalign = i_addr_lo[0];
            end
            LEN_WORD: o_misalign = (i_addr_lo != 2'b00);
            default:  o_misalign = 1'b1;
        endcase
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - fetch/data arbiter for one shared memory port
// Define MEM_ARB_WBUF_EN to add a one-entry posted write buffer (DRAIN state).
module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int IF_PRIO = 0
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_if_req,
    input  logic [ADDR_W-1:0] i_if_addr,
    output logic              o_if_ready,
    output logic [31:0]       o_if_rdata,
    input  logic              i_dm_req,
    input  logic              i_dm_we,
    input  logic [1:0]        i_dm_len,
    input  logic [ADDR_W-1:0] i_dm_addr,
    input  logic [31:0]       i_dm_wdata,
    output logic              o_dm_ready,
    output logic [31:0]       o_dm_rdata,
    output logic              o_dm_misalign,
    output logic              o_stall_if,
    output logic              o_stall_mem,
    output logic              o_mem_req,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [3:0]        o_mem_be,
    output logic [31:0]       o_mem_wdata,
    input  logic              i_mem_ack,
    input  logic [31:0]       i_mem_rdata
);
    import mem_arb_pkg::*;

    localparam logic L_IF_FIRST = (IF_PRIO != 0);

    arb_state_e        r_state;
    arb_state_e        w_next;
    logic              r_mem_req, r_mem_we, r_if_owed, r_dm_owed;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [3:0]        r_mem_be;
    logic [31:0]       r_mem_wdata;

    logic [3:0]        w_be;
    logic [31:0]       w_lane_wdata;
    logic              w_misalign, w_if_first, w_pick_d;
    logic              w_grant_d, w_grant_i, w_if_ready, w_dm_ready, w_dm_misalign;
    logic [ADDR_W-1:0] w_addr;
    logic              w_unused_addr_lo;

    mem_lane_gen u_lane (
        .i_len      (i_dm_len),
        .i_addr_lo  (i_dm_addr[1:0]),
        .i_wdata    (i_dm_wdata),
        .o_be       (w_be),
        .o_wdata    (w_lane_wdata),
        .o_misalign (w_misalign)
    );

    // A requester that lost a tie is owed the next grant, so a back-to-back winner cannot starve it.
    assign w_if_first = r_if_owed | (~r_dm_owed & L_IF_FIRST);
    assign w_pick_d   = i_dm_req & (~i_if_req | ~w_if_first);
    assign w_addr     = w_grant_d ? i_dm_addr : i_if_addr;
    assign w_unused_addr_lo = &{1'b0, w_addr[1:0]};

    always_comb begin
        w_next        = r_state;
        w_grant_d     = 1'b0;
        w_grant_i     = 1'b0;
        w_if_ready    = 1'b0;
        w_dm_ready    = 1'b0;
        w_dm_misalign = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_dm_req && w_misalign) begin
                    w_dm_ready    = 1'b1;
                    w_dm_misalign = 1'b1;
                end else if (w_pick_d) begin
                    w_grant_d = 1'b1;
`ifdef MEM_ARB_WBUF_EN
                    if (i_dm_we) begin
                        w_dm_ready = 1'b1;
                        w_next     = ST_DRAIN;
                    end else begin
                        w_next = ST_BUSY_D;
                    end
`else
                    w_next = ST_BUSY_D;
`endif
                end else if (i_if_req) begin
                    w_grant_i = 1'b1;
                    w_next    = ST_BUSY_I;
                end
            end
            ST_BUSY_I: if (i_mem_ack) begin
                w_if_ready = 1'b1;
                w_next     = ST_IDLE;
            end
            ST_BUSY_D: if (i_mem_ack) begin
                w_dm_ready = 1'b1;
                w_next     = ST_IDLE;
            end
            default: if (i_mem_ack) w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= ST_IDLE;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_be    <= 4'b0000;
            r_mem_wdata <= '0;
            r_if_owed   <= 1'b0;
            r_dm_owed   <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_grant_d || w_grant_i) begin
                r_mem_req   <= 1'b1;
                r_mem_we    <= w_grant_d & i_dm_we;
                r_mem_addr  <= {w_addr[ADDR_W-1:2], 2'b00};
                r_mem_be    <= (w_grant_d && i_dm_we) ? w_be : 4'b1111;
                r_mem_wdata <= (w_grant_d && i_dm_we) ? w_lane_wdata : 32'h0;
                r_if_owed   <= w_grant_d & i_if_req;
                r_dm_owed   <= w_grant_i & i_dm_req;
            end else if (r_state != ST_IDLE && i_mem_ack) begin
                r_mem_req <= 1'b0;
            end
        end
    end

    assign o_if_ready    = w_if_ready;
    assign o_if_rdata    = w_if_ready ? i_mem_rdata : 32'h0;
    assign o_dm_ready    = w_dm_ready;
    assign o_dm_misalign = w_dm_misalign;
    assign o_dm_rdata    = (r_state == ST_BUSY_D && i_mem_ack) ? i_mem_rdata : 32'h0;
    assign o_stall_if    = i_if_req & ~w_if_ready;
    assign o_stall_mem   = i_dm_req & ~w_dm_ready;
    assign o_mem_req     = r_mem_req;
    assign o_mem_we      = r_mem_we;
    assign o_mem_addr    = r_mem_addr;
    assign o_mem_be      = r_mem_be;
    assign o_mem_wdata   = r_mem_wdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

`ifdef MEM_ARB_WBUF_EN
    localparam logic WBUF = 1'b1;
`else
    localparam logic WBUF = 1'b0;
`endif

    logic        clk, rst;
    logic        if_req, dm_req, dm_we, mem_ack;
    logic [31:0] if_addr, dm_addr, dm_wdata, mem_rdata;
    logic [1:0]  dm_len;
    logic        if_ready, dm_ready, dm_misalign, stall_if, stall_mem, mem_req, mem_we;
    logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    int          n_tests = 0;
    int          n_fail  = 0;

    mem_port_arbiter #(.ADDR_W(32), .IF_PRIO(0)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_if_req(if_req), .i_if_addr(if_addr), .o_if_ready(if_ready), .o_if_rdata(if_rdata),
        .i_dm_req(dm_req), .i_dm_we(dm_we), .i_dm_len(dm_len), .i_dm_addr(dm_addr),
        .i_dm_wdata(dm_wdata), .o_dm_ready(dm_ready), .o_dm_rdata(dm_rdata),
        .o_dm_misalign(dm_misalign), .o_stall_if(stall_if), .o_stall_mem(stall_mem),
        .o_mem_req(mem_req), .o_mem_we(mem_we), .o_mem_addr(mem_addr), .o_mem_be(mem_be),
        .o_mem_wdata(mem_wdata), .i_mem_ack(mem_ack), .i_mem_rdata(mem_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic test_reset;
        tick; tick;
        #1;
        n_tests++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL reset_mem_req: got %b want 0", mem_req); end
        n_tests++; if (mem_be !== 4'b0000) begin n_fail++; $display("FAIL reset_mem_be: got %b want 0000", mem_be); end
        n_tests++; if (mem_addr !== 32'h0) begin n_fail++; $display("FAIL reset_mem_addr: got %h want 0", mem_addr); end
        n_tests++; if ({if_ready, dm_ready, dm_misalign, mem_we} !== 4'b0000) begin n_fail++; $display("FAIL reset_flags: got %b want 0000", {if_ready, dm_ready, dm_misalign, mem_we}); end
        tick; rst = 1'b0;
    endtask

    task automatic test_prio;
        tick;
        dm_req = 1; dm_we = 0; dm_len = LEN_WORD; dm_addr = 32'h10; if_req = 1; if_addr = 32'h0;
        #1;
        n_tests++; if ({stall_mem, stall_if, mem_req} !== 3'b110) begin n_fail++; $display("FAIL prio_stalls: got %b want 110", {stall_mem, stall_if, mem_req}); end
        tick; #1;
        n_tests++; if (mem_req !== 1'b1 || mem_addr !== 32'h10) begin n_fail++; $display("FAIL prio_dm_first: got req=%b addr=%h want 1 00000010", mem_req, mem_addr); end
        n_tests++; if (mem_be !== 4'b1111 || mem_we !== 1'b0) begin n_fail++; $display("FAIL prio_load_be: got be=%b we=%b want 1111 0", mem_be, mem_we); end
        tick;
        mem_ack = 1; mem_rdata = 32'h11223344; #1;
        n_tests++; if (dm_ready !== 1'b1 || dm_rdata !== 32'h11223344) begin n_fail++; $display("FAIL prio_dm_ready: got %b %h want 1 11223344", dm_ready, dm_rdata); end
        n_tests++; if (if_ready !== 1'b0 || stall_mem !== 1'b0) begin n_fail++; $display("FAIL prio_if_wait: got if_ready=%b stall_mem=%b want 0 0", if_ready, stall_mem); end
        tick;
        mem_ack = 0; dm_req = 0; #1;
        n_tests++; if (mem_req !== 1'b0 || stall_if !== 1'b1) begin n_fail++; $display("FAIL prio_idle_gap: got req=%b stall_if=%b want 0 1", mem_req, stall_if); end
        tick; #1;
        n_tests++; if (mem_req !== 1'b1 || mem_addr !== 32'h0) begin n_fail++; $display("FAIL prio_if_grant: got req=%b addr=%h want 1 00000000", mem_req, mem_addr); end
        tick;
        mem_ack = 1; mem_rdata = 32'hCAFEF00D; #1;
        n_tests++; if (if_ready !== 1'b1 || if_rdata !== 32'hCAFEF00D || dm_ready !== 1'b0) begin n_fail++; $display("FAIL prio_if_ready: got %b %h dm=%b want 1 cafef00d 0", if_ready, if_rdata, dm_ready); end
        tick;
        mem_ack = 0; if_req = 0;
    endtask

    task automatic test_store;
        logic [1:0]  t_len   [3] = '{LEN_BYTE, LEN_HALF, LEN_WORD};
        logic [31:0] t_addr  [3] = '{32'h13, 32'h22, 32'h44};
        logic [31:0] t_wdata [3] = '{32'h123456AB, 32'h00001234, 32'hDEADBEEF};
        logic [3:0]  t_be    [3] = '{4'b1000, 4'b1100, 4'b1111};
        logic [31:0] t_lanes [3] = '{32'hABABABAB, 32'h12341234, 32'hDEADBEEF};
        logic [31:0] t_maddr [3] = '{32'h10, 32'h20, 32'h44};
        for (int i = 0; i < 3; i++) begin
            tick;
            dm_req = 1; dm_we = 1; dm_len = t_len[i]; dm_addr = t_addr[i]; dm_wdata = t_wdata[i]; #1;
            n_tests++; if (dm_ready !== WBUF || stall_mem !== !WBUF) begin n_fail++; $display("FAIL store%0d_req_cycle: got ready=%b stall=%b want %b %b", i, dm_ready, stall_mem, WBUF, !WBUF); end
            tick;
            if (WBUF) dm_req = 0;
            #1;
            n_tests++; if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== t_maddr[i]) begin n_fail++; $display("FAIL store%0d_issue: got req=%b we=%b addr=%h want 1 1 %h", i, mem_req, mem_we, mem_addr, t_maddr[i]); end
            n_tests++; if (mem_be !== t_be[i] || mem_wdata !== t_lanes[i]) begin n_fail++; $display("FAIL store%0d_lanes: got be=%b wdata=%h want %b %h", i, mem_be, mem_wdata, t_be[i], t_lanes[i]); end
            tick;
            mem_ack = 1; #1;
            n_tests++; if (dm_ready !== !WBUF) begin n_fail++; $display("FAIL store%0d_ack: got ready=%b want %b", i, dm_ready, !WBUF); end
            tick;
            mem_ack = 0; dm_req = 0;
        end
    endtask

    task automatic test_misalign;
        logic [1:0]  t_len  [3] = '{LEN_HALF, LEN_WORD, 2'b11};
        logic [31:0] t_addr [3] = '{32'h21, 32'h22, 32'h20};
        for (int i = 0; i < 3; i++) begin
            tick;
            dm_req = 1; dm_we = 0; dm_len = t_len[i]; dm_addr = t_addr[i]; #1;
            n_tests++; if ({dm_ready, dm_misalign, stall_mem} !== 3'b110 || dm_rdata !== 32'h0) begin n_fail++; $display("FAIL misalign%0d_resp: got rdy/mis/stall=%b rdata=%h want 110 0", i, {dm_ready, dm_misalign, stall_mem}, dm_rdata); end
            tick;
            dm_req = 0; #1;
            n_tests++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL misalign%0d_no_mem: got %b want 0", i, mem_req); end
        end
    endtask

    task automatic test_ack_delay;
        int pulses = 0;
        tick;
        if_req = 1; if_addr = 32'h106;
        tick;
        for (int k = 0; k < 5; k++) begin
            #1;
            n_tests++; if (mem_req !== 1'b1 || mem_addr !== 32'h104 || if_ready !== 1'b0) begin n_fail++; $display("FAIL delay_hold%0d: got req=%b addr=%h rdy=%b want 1 00000104 0", k, mem_req, mem_addr, if_ready); end
            tick;
        end
        mem_ack = 1; mem_rdata = 32'h5A5A0001; #1;
        if (if_ready === 1'b1) pulses++;
        n_tests++; if (if_rdata !== 32'h5A5A0001) begin n_fail++; $display("FAIL delay_rdata: got %h want 5a5a0001", if_rdata); end
        tick;
        mem_ack = 0; if_req = 0; #1;
        if (if_ready === 1'b1) pulses++;
        n_tests++; if (pulses != 1) begin n_fail++; $display("FAIL delay_pulses: got %0d want 1", pulses); end
        n_tests++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL delay_req_drop: got %b want 0", mem_req); end
    endtask

    task automatic test_reset_mid;
        tick;
        dm_req = 1; dm_we = 0; dm_len = LEN_WORD; dm_addr = 32'h80;
        tick; tick;
        rst = 1; #1;
        n_tests++; if (mem_req !== 1'b0 || mem_addr !== 32'h0) begin n_fail++; $display("FAIL rstmid_async: got req=%b addr=%h want 0 0", mem_req, mem_addr); end
        tick;
        rst = 0;
        tick; #1;
        n_tests++; if (mem_req !== 1'b1 || mem_addr !== 32'h80) begin n_fail++; $display("FAIL rstmid_regrant: got req=%b addr=%h want 1 00000080", mem_req, mem_addr); end
        tick;
        mem_ack = 1; mem_rdata = 32'h0BADC0DE; #1;
        n_tests++; if (dm_ready !== 1'b1 || dm_rdata !== 32'h0BADC0DE) begin n_fail++; $display("FAIL rstmid_ready: got %b %h want 1 0badc0de", dm_ready, dm_rdata); end
        tick;
        mem_ack = 0; dm_req = 0;
    endtask

    task automatic test_back_to_back;
        tick;
        dm_req = 1; dm_we = 0; dm_len = LEN_WORD; dm_addr = 32'h200; if_req = 1; if_addr = 32'h300;
        tick; #1;
        n_tests++; if (mem_addr !== 32'h200) begin n_fail++; $display("FAIL b2b_first: got %h want 00000200", mem_addr); end
        tick;
        mem_ack = 1; mem_rdata = 32'h1; #1;
        tick;
        mem_ack = 0; #1;
        n_tests++; if (mem_req !== 1'b0 || {stall_mem, stall_if} !== 2'b11) begin n_fail++; $display("FAIL b2b_gap: got req=%b stalls=%b want 0 11", mem_req, {stall_mem, stall_if}); end
        tick; #1;
        n_tests++; if (mem_req !== 1'b1 || mem_addr !== 32'h300) begin n_fail++; $display("FAIL b2b_loser_next: got req=%b addr=%h want 1 00000300", mem_req, mem_addr); end
        tick;
        mem_ack = 1; mem_rdata = 32'h2; #1;
        n_tests++; if (if_ready !== 1'b1 || dm_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_if_ready: got if=%b dm=%b want 1 0", if_ready, dm_ready); end
        tick;
        mem_ack = 0; if_req = 0;
        tick; #1;
        n_tests++; if (mem_req !== 1'b1 || mem_addr !== 32'h200) begin n_fail++; $display("FAIL b2b_dm_again: got req=%b addr=%h want 1 00000200", mem_req, mem_addr); end
        tick;
        mem_ack = 1; mem_rdata = 32'h3; #1;
        n_tests++; if (dm_ready !== 1'b1 || dm_rdata !== 32'h3) begin n_fail++; $display("FAIL b2b_dm_ready: got %b %h want 1 00000003", dm_ready, dm_rdata); end
        tick;
        mem_ack = 0; dm_req = 0;
    endtask

`ifdef MEM_ARB_WBUF_EN
    task automatic test_wbuf;
        tick;
        dm_req = 1; dm_we = 1; dm_len = LEN_WORD; dm_addr = 32'h40; dm_wdata = 32'h01020304; #1;
        n_tests++; if (dm_ready !== 1'b1 || dm_misalign !== 1'b0) begin n_fail++; $display("FAIL wbuf_post: got %b %b want 1 0", dm_ready, dm_misalign); end
        tick;
        dm_we = 0; #1;
        n_tests++; if (mem_req !== 1'b1 || mem_we !== 1'b1 || stall_mem !== 1'b1) begin n_fail++; $display("FAIL wbuf_drain: got req=%b we=%b stall=%b want 1 1 1", mem_req, mem_we, stall_mem); end
        tick;
        mem_ack = 1; #1;
        n_tests++; if (dm_ready !== 1'b0) begin n_fail++; $display("FAIL wbuf_drain_ack: got %b want 0", dm_ready); end
        tick;
        mem_ack = 0; #1;
        tick; #1;
        n_tests++; if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h40) begin n_fail++; $display("FAIL wbuf_load: got req=%b we=%b addr=%h want 1 0 00000040", mem_req, mem_we, mem_addr); end
        tick;
        mem_ack = 1; mem_rdata = 32'h01020304; #1;
        n_tests++; if (dm_ready !== 1'b1 || dm_rdata !== 32'h01020304) begin n_fail++; $display("FAIL wbuf_load_ready: got %b %h want 1 01020304", dm_ready, dm_rdata); end
        tick;
        mem_ack = 0; dm_req = 0;
    endtask
`endif

    initial begin
        rst = 1; if_req = 0; if_addr = 0; dm_req = 0; dm_we = 0; dm_len = 0;
        dm_addr = 0; dm_wdata = 0; mem_ack = 0; mem_rdata = 0;
        test_reset;
        test_prio;
        test_store;
        test_misalign;
        test_ack_delay;
        test_reset_mid;
        test_back_to_back;
`ifdef MEM_ARB_WBUF_EN
        test_wbuf;
`endif
        tick;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
